// File: rtl/pim_pkg.sv
// rtl/pim_pkg.sv - shared PIM types and word width
package pim_pkg;

  // Width of one PIM result/immediate word.
  localparam int PIM_WORD_W = 25;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } collector_state_t;

endpackage

// File: rtl/pim_result_collector.sv
// rtl/pim_result_collector.sv - LSB-first bit-serial result deserializer with valid/ready output
module pim_result_collector
  import pim_pkg::*;
#(
  parameter int N = PIM_WORD_W,
  localparam int LW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          bit_in,
  input  logic          bit_valid,
  output logic          busy,
  output logic [N-1:0]  result,
  output logic          result_valid,
  input  logic          result_ready,
  output logic          overrun
);

  collector_state_t r_state;
  collector_state_t w_next_state;
  logic [N-1:0]     r_result;
  logic [LW-1:0]    r_cnt;
  logic [LW-1:0]    r_len_q;
  logic             r_overrun;
  logic [LW-1:0]    w_len_clamp;
  logic             w_last_bit;

  // A zero or oversized length means a full word.
  assign w_len_clamp = ((len == '0) || (len > LW'(N))) ? LW'(N) : len;
  assign w_last_bit  = (r_cnt == (r_len_q - 1'b1));

  // Next state: start overrides everything, including a pending handshake.
  always_comb begin
    w_next_state = r_state;
    if (start) begin
      w_next_state = COLLECT;
    end else begin
      case (r_state)
        COLLECT: if (bit_valid && w_last_bit) w_next_state = DONE;
        DONE:    if (result_ready) w_next_state = IDLE;
        default: w_next_state = r_state;
      endcase
    end
  end

  // State, bit counter, assembled word and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_result  <= '0;
      r_cnt     <= '0;
      r_len_q   <= '0;
      r_overrun <= 1'b0;
    end else if (start) begin
      // A bit arriving alongside start belongs to no collection and is ignored.
      r_state   <= w_next_state;
      r_result  <= '0;
      r_cnt     <= '0;
      r_len_q   <= w_len_clamp;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (bit_valid) begin
        if (r_state == COLLECT) begin
          r_result[r_cnt] <= bit_in;
          r_cnt           <= r_cnt + 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign busy         = (r_state == COLLECT);
  assign result_valid = (r_state == DONE);
  assign result       = r_result;
  assign overrun      = r_overrun;

endmodule
